// File: rtl/aes_pkg.sv
// Shared AES decipher definitions: FSM states, word slicing and the InvShiftRows permutation.
package aes_pkg;

   typedef enum logic {IDLE, SUB} state_t;

   localparam int AES_WORDS = 4;
   localparam int WORD_W    = 32;
   localparam int BLOCK_W   = 128;

   // Word 0 sits in the top 32 bits, so the LSB of word idx is (3 - idx) * 32.
   function automatic logic [6:0] word_lsb(input logic [1:0] idx);
      return {~idx, 5'b00000};
   endfunction

   function automatic logic [BLOCK_W-1:0] inv_shiftrows(input logic [BLOCK_W-1:0] blk);
      logic [BLOCK_W-1:0] res;
      res = '0;
      for (int c = 0; c < AES_WORDS; c++) begin
         for (int r = 0; r < 4; r++) begin
            res[BLOCK_W-1-WORD_W*c-8*r -: 8] = blk[BLOCK_W-1-WORD_W*((c-r+4)%4)-8*r -: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/aes_inv_shiftrows.sv
// Combinational InvShiftRows over a full 128-bit AES state.
module aes_inv_shiftrows
   import aes_pkg::*;
(
   input  logic [BLOCK_W-1:0] block_in,
   output logic [BLOCK_W-1:0] block_out
);

   assign block_out = inv_shiftrows(block_in);

endmodule

// File: rtl/aes_inv_subbytes_seq.sv
// Word-serial InvShiftRows + InvSubBytes stage; the inverse S-box lives outside and is reached via sboxw/new_sboxw.
module aes_inv_subbytes_seq
   import aes_pkg::*;
#(
   parameter bit INV_SHIFT_EN = 1'b1
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [BLOCK_W-1:0] block_in,
   output logic               ready,
   output logic               result_valid,
   output logic [BLOCK_W-1:0] block_out,
   output logic [WORD_W-1:0]  sboxw,
   input  logic [WORD_W-1:0]  new_sboxw
);

   state_t             state;
   state_t             state_next;
   logic [1:0]         word_ctr;
   logic [BLOCK_W-1:0] state_reg;
   logic [BLOCK_W-1:0] shifted_block;
   logic [BLOCK_W-1:0] capture_block;
   logic               accept;

   aes_inv_shiftrows u_inv_shiftrows (
      .block_in  (block_in),
      .block_out (shifted_block)
   );

   assign capture_block = INV_SHIFT_EN ? shifted_block : block_in;
   assign accept        = (state == IDLE) && start;
   assign ready         = (state == IDLE);
   assign block_out     = state_reg;

   // Hold the shared S-box input at zero while idle so it does not toggle.
   assign sboxw = (state == SUB) ? state_reg[word_lsb(word_ctr) +: WORD_W] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SUB;
         SUB:     if (word_ctr == 2'd3) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One column substituted per cycle; the last write also flags the result valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= '0;
         word_ctr     <= 2'd0;
         result_valid <= 1'b0;
      end else if (accept) begin
         state_reg    <= capture_block;
         word_ctr     <= 2'd0;
         result_valid <= 1'b0;
      end else if (state == SUB) begin
         state_reg[word_lsb(word_ctr) +: WORD_W] <= new_sboxw;
         word_ctr <= word_ctr + 2'd1;
         if (word_ctr == 2'd3) begin
            result_valid <= 1'b1;
         end
      end
   end

endmodule
